mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit, width-parametrised, sitting beside the combinational ALU in the execute stage. It accepts one operation through a valid/ready request handshake and computes it with a radix-2 shift-add (multiply) or restoring shift-subtract (divide) datapath. It returns the XLEN-bit result through a valid/ready response handshake. A kill input lets the core abort an in-flight operation on flush.

Parameters:
XLEN, 32, operand/result width; legal values 8..64, even.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
operand_a  in  XLEN  rs1 / dividend.
operand_b  in  XLEN  rs2 / divisor.
kill  in  1  synchronous abort of the in-flight operation.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes the result.
resp_data  out  XLEN  result.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, counter=0, all datapath registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op and operands; take magnitudes of signed operands (MULH: a and b signed; MULHSU: a only; DIV/REM: both).
  - Record the result sign. Load counter=XLEN. Go to CALC.
- CALC:
  - One iteration per cycle; counter decrements; after XLEN iterations go to FIX.
  - Multiply keeps a 2*XLEN product register.
  - Divide keeps the quotient and a remainder register of XLEN+1 bits.
- FIX: one cycle.
  - Apply sign correction (two's-complement negate where required).
  - Select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient, or remainder into resp_data. Go to DONE.
- DONE:
  - resp_valid=1; resp_data held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE.
  - Back-to-back: req_ready stays 0 in DONE; a new request is accepted only from IDLE, one cycle after the response handshake.
- Latency: resp_valid rises XLEN+2 clock edges after the accepting edge (34 for XLEN=32).
- req_ready=0 in CALC, FIX and DONE. req_op and operands are don't-care outside an accepting cycle.
- Division by zero (no trap):
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = operand_a.
- Signed overflow (operand_a = 1 followed by XLEN-1 zeros, operand_b = all ones):
  - DIV quotient = operand_a.
  - REM remainder = 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Both special cases still take the full XLEN+2 latency unless MDU_EARLY_OUT_EN is defined.
- kill:
  - In CALC or FIX: state goes to IDLE at the next edge; no response is produced.
  - In DONE: the pending response is dropped and state returns to IDLE.
  - In IDLE: kill has priority over req_valid, so nothing is accepted.
- Reset asserted mid-operation: everything returns to reset values immediately; no response is produced.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: division by zero, the signed-overflow case, and either multiply operand equal to zero bypass CALC.
  - IDLE goes directly to FIX, with the result preloaded to the architectural value above (0 for a zero multiply).
  - resp_valid rises 2 edges after acceptance.
- Undefined: every operation takes XLEN+2 edges; no extra comparators are instantiated.

Test Plan:
- MUL/MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE. resp_valid exactly 34 edges after acceptance.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases:
  - DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - With MDU_EARLY_OUT_EN: each of these returns 2 edges after acceptance.
- Handshake:
  - Hold resp_ready=0 for 5 cycles in DONE: resp_data stable, req_ready=0.
  - Then resp_ready=1 with req_valid=1: the next request is accepted one cycle later.
- Aborts:
  - Pulse kill 10 cycles into a DIV: no resp_valid ever; req_ready=1 next cycle; the following MUL 3*5 -> 15.
  - Assert rst_n=0 mid-CALC: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mul_div_unit                                                  |
// | Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring |
// | shift-subtract divide. Optional macro MDU_EARLY_OUT_EN adds zero and   |
// | overflow bypass.                                                       |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_b_zero, w_sign;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;

    assign w_is_div   = req_op[2];
    assign w_a_signed = (req_op == c_OP_MULH) || (req_op == c_OP_MULHSU) ||
                        (req_op == c_OP_DIV)  || (req_op == c_OP_REM);
    assign w_b_signed = (req_op == c_OP_MULH) || (req_op == c_OP_DIV) || (req_op == c_OP_REM);
    assign w_a_neg    = w_a_signed & operand_a[XLEN-1];
    assign w_b_neg    = w_b_signed & operand_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
    assign w_b_mag    = w_b_neg ? -operand_b : operand_b;
    assign w_b_zero   = (operand_b == '0);
    // Remainder takes the dividend sign; a zero divisor must leave the all-ones quotient unnegated.
    assign w_sign     = (w_is_div && req_op[1]) ? w_a_neg
                                                : ((w_a_neg ^ w_b_neg) && !(w_is_div && w_b_zero));

`ifdef MDU_EARLY_OUT_EN
    logic w_ovf, w_early;
    assign w_ovf   = ((req_op == c_OP_DIV) || (req_op == c_OP_REM)) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
    assign w_early = w_is_div ? (w_b_zero || w_ovf) : ((operand_a == '0) || w_b_zero);
`endif

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN+1:0]   w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_result;

    always_comb begin
        w_mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, bmag_q} : '0);
        w_div_shift = {rem_q, quot_q[XLEN-1]};
        w_div_diff  = w_div_shift - {2'b00, bmag_q};
        w_prod_fix  = neg_q ? -prod_q : prod_q;
        w_quot_fix  = neg_q ? -quot_q : quot_q;
        w_rem_fix   = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            c_OP_MUL:                          w_result = w_prod_fix[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:               w_result = w_quot_fix;
            default:                           w_result = w_rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        bmag_d  = bmag_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !kill) begin
                    op_d    = req_op;
                    neg_d   = w_sign;
                    cnt_d   = CNT_W'(XLEN);
                    prod_d  = {{XLEN{1'b0}}, w_a_mag};
                    bmag_d  = w_b_mag;
                    quot_d  = w_a_mag;
                    rem_d   = '0;
                    state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
                    if (w_early) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                        prod_d  = '0;
                        if (w_b_zero) begin
                            quot_d = '1;
                            rem_d  = {1'b0, w_a_mag};
                        end
                    end
`endif
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        rem_d  = w_div_diff[XLEN+1] ? w_div_shift[XLEN:0] : w_div_diff[XLEN:0];
                        quot_d = {quot_q[XLEN-2:0], ~w_div_diff[XLEN+1]};
                    end else begin
                        prod_d = {w_mul_sum, prod_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = w_result;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (kill || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            bmag_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            bmag_q  <= bmag_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mul_div_unit                                               |
// | Directed self-checking bench for mul_div_unit (XLEN=32).               |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_mul_div_unit;
    localparam int XLEN    = 32;
    localparam int FULL_LAT = XLEN + 2;
`ifdef MDU_EARLY_OUT_EN
    localparam int SP_LAT = 2;
`else
    localparam int SP_LAT = XLEN + 2;
`endif

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic wait_resp(input logic [31:0] exp_data, input int exp_lat, input string tag);
        int edges;
        edges = 1;
        while (!resp_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        chk({tag, "_data"}, 64'(resp_data), 64'(exp_data));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        operand_a  = '0;
        operand_b  = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_req_ready",  64'(req_ready),  64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data",  64'(resp_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul");     wait_resp(32'h00000001, FULL_LAT, "mul");     consume("mul");
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");   wait_resp(32'hFFFFFFFE, FULL_LAT, "mulhu");   consume("mulhu");
        issue(3'd1, 32'h80000000, 32'h80000000, "mulh");    wait_resp(32'h40000000, FULL_LAT, "mulh");    consume("mulh");
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");  wait_resp(32'hFFFFFFFF, FULL_LAT, "mulhsu");  consume("mulhsu");
        issue(3'd4, 32'hFFFFFFF9, 32'd2, "div");            wait_resp(32'hFFFFFFFD, FULL_LAT, "div");     consume("div");
        issue(3'd6, 32'hFFFFFFF9, 32'd2, "rem");            wait_resp(32'hFFFFFFFF, FULL_LAT, "rem");     consume("rem");
        issue(3'd5, 32'd100, 32'd7, "divu");                wait_resp(32'd14, FULL_LAT, "divu");          consume("divu");
        issue(3'd7, 32'd100, 32'd7, "remu");                wait_resp(32'd2, FULL_LAT, "remu");           consume("remu");

        issue(3'd5, 32'd7, 32'd0, "divu0");                 wait_resp(32'hFFFFFFFF, SP_LAT, "divu0");     consume("divu0");
        issue(3'd6, 32'd7, 32'd0, "rem0");                  wait_resp(32'd7, SP_LAT, "rem0");             consume("rem0");
        issue(3'd4, 32'hFFFFFFF9, 32'd0, "divneg0");        wait_resp(32'hFFFFFFFF, SP_LAT, "divneg0");   consume("divneg0");
        issue(3'd6, 32'hFFFFFFF9, 32'd0, "remneg0");        wait_resp(32'hFFFFFFF9, SP_LAT, "remneg0");   consume("remneg0");
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, "divovf");  wait_resp(32'h80000000, SP_LAT, "divovf");    consume("divovf");
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, "removf");  wait_resp(32'd0, SP_LAT, "removf");           consume("removf");
        issue(3'd0, 32'd0, 32'd5, "mulz");                  wait_resp(32'd0, SP_LAT, "mulz");             consume("mulz");

        // Response back-pressure, then a request presented together with the handshake.
        issue(3'd0, 32'd3, 32'd5, "hs");
        wait_resp(32'd15, FULL_LAT, "hs");
        repeat (5) begin
            @(negedge clk);
            chk("hs_hold_data",  64'(resp_data),  64'd15);
            chk("hs_hold_valid", 64'(resp_valid), 64'd1);
            chk("hs_hold_ready", 64'(req_ready),  64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = 3'd5;
        operand_a  = 32'd9;
        operand_b  = 32'd3;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("b2b_idle_ready", 64'(req_ready),  64'd1);
        chk("b2b_idle_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepted", 64'(req_ready), 64'd0);
        wait_resp(32'd3, FULL_LAT, "b2b");
        consume("b2b");

        // Kill mid-divide.
        issue(3'd5, 32'd100, 32'd7, "kcalc");
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kcalc_ready", 64'(req_ready),  64'd1);
        chk("kcalc_valid", 64'(resp_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1;
        end
        chk("kcalc_no_resp", 64'(seen), 64'd0);
        issue(3'd0, 32'd3, 32'd5, "after_kill"); wait_resp(32'd15, FULL_LAT, "after_kill"); consume("after_kill");

        // Kill in DONE drops the pending response.
        issue(3'd0, 32'd2, 32'd7, "kdone");
        wait_resp(32'd14, FULL_LAT, "kdone");
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kdone_valid", 64'(resp_valid), 64'd0);
        chk("kdone_ready", 64'(req_ready),  64'd1);

        // Kill in IDLE blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1;
        kill      = 1'b1;
        req_op    = 3'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        chk("kidle_not_accepted", 64'(req_ready), 64'd1);

        // Asynchronous reset mid-CALC.
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "arst");
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready",  64'(req_ready),  64'd1);
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_resp_data",  64'(resp_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1;
        end
        chk("arst_no_resp", 64'(seen), 64'd0);
        issue(3'd7, 32'd23, 32'd5, "after_rst"); wait_resp(32'd3, FULL_LAT, "after_rst"); consume("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
